// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial A - B - BIN, one bit per clock, with start/busy/done handshake
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             OVF,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, res_q, res_d, d_q, d_d;
    logic             br_q, br_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic             bout_q, bout_d, ovf_q, ovf_d;
    logic             bit_d, bit_b, last;
    logic [WIDTH-1:0] res_next;

    assign bit_d    = ra_q[0] ^ rb_q[0] ^ br_q;
    assign bit_b    = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    assign res_next = {bit_d, res_q[WIDTH-1:1]};
    assign last     = cnt_q == CW'(WIDTH - 1);

    assign D    = d_q;
    assign BOUT = bout_q;
    assign OVF  = ovf_q;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;

    // next state: accept operands when idle/done, otherwise step one bit per clock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        br_d    = br_q;
        res_d   = res_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            RUN: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                br_d  = bit_b;
                res_d = res_next;
                cnt_d = last ? '0 : cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    d_d     = res_next;
                    bout_d  = bit_b;
                    ovf_d   = (a_msb_q != b_msb_q) & (res_next[WIDTH-1] != a_msb_q);
                end
            end
            default: begin
                state_d = start ? RUN : IDLE;
                if (start) begin
                    ra_d    = A;
                    rb_d    = B;
                    br_d    = BIN;
                    res_d   = '0;
                    cnt_d   = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1];
                end
            end
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            br_q    <= 1'b0;
            res_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            br_q    <= br_d;
            res_q   <= res_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: scoreboard bench for the bit-serial subtractor
module tb_serial_sub4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] A = '0, B = '0;
    logic       BIN = 1'b0;
    logic [3:0] D;
    logic       BOUT, OVF, busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] exp_q[$];

    serial_sub4 #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .BIN(BIN),
        .D(D), .BOUT(BOUT), .OVF(OVF), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
        logic [4:0] u;
        int s;
        u = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        s = int'($signed(a)) - int'($signed(b)) - int'(bin);
        return {u[3:0], u[4], (s < -8 || s > 7)};
    endfunction

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; BIN = bin; start = 1'b1;
        exp_q.push_back(model(a, b, bin));
        @(posedge clk);
        #1 start = 1'b0;
        A = 4'($urandom); B = 4'($urandom); BIN = 1'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({D, BOUT, OVF, busy, done} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state got %b want 00000000", {D, BOUT, OVF, busy, done});
        end
    endtask

    task automatic test_basic;
        int n;
        logic [5:0] e;
        issue(4'b0011, 4'b0110, 1'b0);
        wait_done(n);
        e = exp_q.pop_front();
        n_cmp++;
        if (n !== 5) begin
            n_bad++;
            $display("FAIL basic_latency got %0d want 5", n);
        end
        n_cmp++;
        if ({done, D, BOUT, OVF} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL basic_result got %b want %b", {done, D, BOUT, OVF}, {1'b1, e});
        end
        @(negedge clk);
        n_cmp++;
        if ({done, D} !== {1'b0, e[5:2]}) begin
            n_bad++;
            $display("FAIL done_pulse got %b want %b", {done, D}, {1'b0, e[5:2]});
        end
    endtask

    task automatic test_values;
        logic [8:0] tbl[4] = '{9'b1100_0110_0, 9'b0000_0000_0, 9'b1000_0111_1, 9'b1111_1111_1};
        int n;
        logic [5:0] e;
        for (int i = 0; i < 4; i++) begin
            issue(tbl[i][8:5], tbl[i][4:1], tbl[i][0]);
            wait_done(n);
            e = exp_q.pop_front();
            n_cmp++;
            if ({done, D, BOUT, OVF} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL values_%0d got %b want %b", i, {done, D, BOUT, OVF}, {1'b1, e});
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [5:0] e;
        @(negedge clk);
        A = 4'b0011; B = 4'b0001; BIN = 1'b0; start = 1'b1;
        exp_q.push_back(model(4'b0011, 4'b0001, 1'b0));
        exp_q.push_back(model(4'b0101, 4'b0010, 1'b0));
        @(posedge clk);
        #1 A = 4'b0101; B = 4'b0010;
        wait_done(n);
        e = exp_q.pop_front();
        n_cmp++;
        if ({n[4:0], done, D, BOUT, OVF} !== {5'd5, 1'b1, e}) begin
            n_bad++;
            $display("FAIL b2b_first got n=%0d %b want n=5 %b", n, {done, D, BOUT, OVF}, {1'b1, e});
        end
        wait_done(n);
        start = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if ({n[4:0], done, D, BOUT, OVF} !== {5'd5, 1'b1, e}) begin
            n_bad++;
            $display("FAIL b2b_second got n=%0d %b want n=5 %b", n, {done, D, BOUT, OVF}, {1'b1, e});
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_idle got %b want 00", {busy, done});
        end
    endtask

    task automatic test_abort;
        int n, seen;
        logic [5:0] e;
        logic [3:0] prev_d;
        prev_d = D;
        issue(4'b1111, 4'b0001, 1'b0);
        void'(exp_q.pop_back());
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, D} !== {2'b10, prev_d}) begin
            n_bad++;
            $display("FAIL hold_while_busy got %b want %b", {busy, done, D}, {2'b10, prev_d});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({D, BOUT, OVF, busy, done} !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset got %b want 00000000", {D, BOUT, OVF, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(done);
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL abort_no_done got %0d want 0", seen);
        end
        issue(4'b1111, 4'b0001, 1'b0);
        wait_done(n);
        e = exp_q.pop_front();
        n_cmp++;
        if ({done, D, BOUT, OVF} !== {1'b1, e}) begin
            n_bad++;
            $display("FAIL after_abort got %b want %b", {done, D, BOUT, OVF}, {1'b1, e});
        end
    endtask

    task automatic test_sweep;
        int n;
        logic [5:0] e;
        for (int i = 0; i < 512; i++) begin
            issue(4'(i >> 5), 4'(i >> 1), 1'(i));
            wait_done(n);
            e = exp_q.pop_front();
            n_cmp++;
            if ({done, D, BOUT, OVF} !== {1'b1, e}) begin
                n_bad++;
                $display("FAIL sweep a=%h b=%h bin=%0d got %b want %b", 4'(i >> 5), 4'(i >> 1), i & 1, {done, D, BOUT, OVF}, {1'b1, e});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_back_to_back();
        test_abort();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_sub4.md
Name: serial_sub4

Overview:
- Sequential bit-serial subtractor; the inverse-direction counterpart to the team's 4-bit ripple adder (A, B, carry-in → F, COUT).
- Computes D = A − B − BIN one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Uses a start/busy/done handshake.
- Used in the lab datapath wherever a difference or borrow is needed with minimal logic. Also serves as a cross-check against the adder by computing A + (~B) + 1.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  minuend; latched on an accepted start.
- B  input  WIDTH  subtrahend; latched on an accepted start.
- BIN  input  1  borrow-in; latched on an accepted start.
- D  output  WIDTH  difference; registered.
- BOUT  output  1  borrow-out (1 = unsigned A < B + BIN); registered.
- OVF  output  1  signed two's-complement overflow; registered.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when D, BOUT and OVF are updated.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; D=0, BOUT=0, OVF=0, busy=0, done=0; bit counter, shift registers and borrow register cleared. Reset asserted mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1. Latch A→ra, B→rb, BIN→br, counter=0, busy=1.
  - RUN, each edge:
    - Compute the bit: d = ra[0]^rb[0]^br; br_next = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br).
    - Shift d into the MSB of the result register; shift ra and rb right by 1; counter+1.
    - The edge processing bit WIDTH−1 transitions to DONE.
  - On the RUN→DONE edge: D ← full result; BOUT ← final borrow; OVF ← (A[MSB]≠B[MSB]) & (D[MSB]≠A[MSB]), using the latched original operands; done=1, busy=0.
  - DONE lasts one cycle.
    - If start=1, accept new operands (back-to-back) → RUN.
    - Otherwise → IDLE.
- Latency: start sampled at edge k → done high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored; no queuing. A, B and BIN may change freely after acceptance.
- D, BOUT and OVF hold their last values until the next done. They never show partial results.
- BIN=1 with A=B gives D = all ones, BOUT=1.
- The counter wraps only through the FSM; no free-running wrap.

Test Plan:
1. After reset: D=0000, BOUT=0, OVF=0, busy=0, done=0. Then A=0011, B=0110, BIN=0, start pulse → done exactly 5 cycles after the start edge, D=1101, BOUT=1, OVF=0.
2. A=1100, B=0110, BIN=0 → D=0110, BOUT=0, OVF=1. Then A=0000, B=0000, BIN=0 → D=0000, BOUT=0, OVF=0.
3. A=1000, B=0111, BIN=1 → D=0000, BOUT=0, OVF=1. Then A=1111, B=1111, BIN=1 → D=1111, BOUT=1, OVF=0.
4. Hold start high continuously through two operations (0011−0001, then 0101−0010) → done pulses 5 cycles apart. D=0010, then D=0011. A start during RUN does not restart the operation.
5. Start A=1111, B=0001; pull rst_n low at cycle 2 for 1 cycle → all outputs 0 immediately, no done. A new start afterwards computes 1110, BOUT=0.
6. Exhaustive sweep of all 512 combinations of A, B, BIN, one after another → {BOUT, D} equals (A − B − BIN) mod 32 for every case, and OVF matches the signed reference.
